rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Shares one unified single-ported memory between the pipeline's instruction-fetch (IF) port and data-access (MEM) port.
- Sequences each transfer with a req/ack handshake toward memory. Returns per-port ready pulses that the pipeline uses as stall-release.
- Sits between the pipeline core's PC/Instr and ALUResult/WriteData/ReadData/MemWrite ports and the memory model.

Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before IF is forced a grant (1..15).
- TIMEOUT_CYCLES, 255, cycles without mem_ack before a transfer is aborted (used only with the optional feature; 1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch address (PC)
- if_rdata  out  32  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle pulse, fetch complete
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store (MemWrite), 0 = load
- d_addr  in  32  data address (ALUResult)
- d_wdata  in  32  store data (WriteData)
- d_rdata  out  32  load data, valid when d_ready=1
- d_ready  out  1  one-cycle pulse, data access complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, single-cycle
- mem_err  out  1  one-cycle pulse on timeout abort (tied 0 without the optional feature)

Behaviour:
- Reset:
  - All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata, mem_err.
  - FSM state = IDLE; starve counter = 0; timeout counter = 0.
  - Reset asserted mid-transfer drops mem_req immediately (asynchronous). No ready pulse is issued for the killed transfer.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If d_req=1 and (if_req=0 or starve<STARVE_LIMIT): go to BUSY_D. Register d_addr, d_wdata and d_we into mem_*; set mem_req=1.
    - If if_req=1 at that grant, starve is incremented (saturating at STARVE_LIMIT).
  - Else if if_req=1: go to BUSY_I. Register if_addr; mem_we=0; mem_req=1; starve=0.
  - Else stay in IDLE with mem_req=0.
- Latency: a request sampled in IDLE at edge N drives mem_req=1 after edge N. Minimum request-to-ready is 2 cycles with a zero-wait memory (ack in the first mem_req cycle).
- BUSY_x, on mem_ack=1 at edge M:
  - Capture mem_rdata into if_rdata or d_rdata.
  - Pulse the matching ready for exactly one cycle after edge M.
  - Drop mem_req and return to IDLE.
  - A new grant is evaluated no earlier than edge M+1, giving one bubble cycle between transfers.
- rdata outputs hold their last captured value until the next completion on the same port. Store completions leave d_rdata unchanged.
- mem_addr, mem_we and mem_wdata stay stable for the whole BUSY period. Changes on requester inputs during BUSY are ignored.
- If a requester drops req mid-transfer, the transfer still completes and ready still pulses.
- mem_ack while in IDLE is ignored.
- if_ready and d_ready are never asserted in the same cycle.
- Starvation: with d_req held high continuously and if_req pending, IF is granted after exactly STARVE_LIMIT data grants.

Optional Feature:
- Macro: RV_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY_x and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, return to IDLE, pulse the matching ready with rdata=0x00000000, and pulse mem_err for one cycle, all in the same cycle.
  - mem_ack in the same cycle as the timeout takes priority: normal completion, no mem_err.
- Undefined: no counter is built; mem_err is tied 0; BUSY waits indefinitely for mem_ack.

Test Plan:
- IF-only: if_req=1, if_addr=0x00000010, mem acks after 2 wait cycles with rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_rdata=0x00500093, if_ready pulses once, 4 cycles after request.
- Simultaneous: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, zero-wait memory -> data served first (mem_we=1, mem_wdata=0xDEADBEEF), d_ready pulses, then IF served after one bubble; d_rdata unchanged.
- Starvation: d_req held 1 with a new address each grant, if_req=1, STARVE_LIMIT=4 -> exactly 4 d_ready pulses, then if_ready, then data resumes.
- Reset mid-transfer: assert reset while in BUSY_D with mem_ack withheld -> mem_req=0 in the same cycle, no d_ready, FSM in IDLE; after release, a fresh if_req is served normally.
- Stability: change d_addr from 0x200 to 0x300 during BUSY_D -> mem_addr stays 0x200 until mem_ack.
- With RV_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ack never asserted -> after 8 BUSY cycles mem_req=0, if_ready=1, if_rdata=0, mem_err=1, each for one cycle.

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
//-----------------------------------------------------------------------------
// rv_mem_arbiter_if
// Bundles every signal between the arbiter, the pipeline core and the
// unified single-ported memory.
//
// Signals:
//   if_req/if_addr          fetch request and PC, held until if_ready
//   if_rdata/if_ready       fetched instruction and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata                 data request (MemWrite, ALUResult, WriteData),
//                           held until d_ready
//   d_rdata/d_ready         load data and one-cycle completion pulse
//   mem_req/mem_we/
//   mem_addr/mem_wdata      request toward memory, held until mem_ack
//   mem_rdata/mem_ack       memory read data and single-cycle completion
//   mem_err                 one-cycle pulse on a timeout abort
//
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding pipeline/memory view
//-----------------------------------------------------------------------------
interface rv_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_err
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
//-----------------------------------------------------------------------------
// rv_mem_arbiter
// Shares one unified single-ported memory between the instruction-fetch (IF)
// port and the data-access (MEM) port of the pipeline. Each transfer runs a
// req/ack handshake toward memory; completion is reported to the pipeline as
// a one-cycle ready pulse that releases the corresponding stall.
//
// Arbitration: data has priority, but after STARVE_LIMIT consecutive data
// grants with a fetch pending, the fetch is forced through.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - rv_mem_arbiter_if.slave (pipeline IF/MEM ports + memory side)
//
// Parameters:
//   STARVE_LIMIT   - data grants tolerated while a fetch waits (1..15)
//   TIMEOUT_CYCLES - BUSY cycles without mem_ack before abort (1..255),
//                    only meaningful with RV_MEM_TIMEOUT_EN
//
// Build option:
//   RV_MEM_TIMEOUT_EN - when defined, an 8-bit watchdog aborts a transfer
//                       that sees no mem_ack for TIMEOUT_CYCLES BUSY cycles,
//                       returning rdata=0 with the ready pulse and a one-cycle
//                       mem_err. When undefined, BUSY waits indefinitely and
//                       mem_err stays 0.
//
// All outputs are registered.
//-----------------------------------------------------------------------------
module rv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  rv_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Elaboration-time guard on the configuration ranges.
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve
    $error("rv_mem_arbiter: STARVE_LIMIT out of range 1..15");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("rv_mem_arbiter: TIMEOUT_CYCLES out of range 1..255");
  end

  // Saturating increment of the 4-bit starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val,
                                          input logic [3:0] lim);
    logic [3:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  starve_r, starve_s;

  logic        mem_req_r, mem_req_s;
  logic        mem_we_r, mem_we_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic [31:0] if_rdata_r, if_rdata_s;
  logic [31:0] d_rdata_r, d_rdata_s;
  logic        if_ready_r, if_ready_s;
  logic        d_ready_r, d_ready_s;
  logic        mem_err_r, mem_err_s;

  // Data grant condition: data wins unless a fetch has waited too long.
  logic        grant_d_s;
  assign grant_d_s = bus.d_req && (!bus.if_req || (starve_r < STARVE_MAX));

`ifdef RV_MEM_TIMEOUT_EN
  // The abort fires in the BUSY cycle whose count equals TIMEOUT_CYCLES-1,
  // i.e. after exactly TIMEOUT_CYCLES ack-less BUSY cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  tmo_r, tmo_s;
`endif

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_s     = state_r;
    starve_s    = starve_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if_rdata_s  = if_rdata_r;
    d_rdata_s   = d_rdata_r;
    if_ready_s  = 1'b0;
    d_ready_s   = 1'b0;
    mem_err_s   = 1'b0;
`ifdef RV_MEM_TIMEOUT_EN
    tmo_s       = tmo_r;
`endif

    case (state_r)
      IDLE: begin
        mem_req_s = 1'b0;
        if (grant_d_s) begin
          state_s     = BUSY_D;
          mem_req_s   = 1'b1;
          mem_we_s    = bus.d_we;
          mem_addr_s  = bus.d_addr;
          mem_wdata_s = bus.d_wdata;
          // Only grants that bypass a waiting fetch count toward starvation.
          if (bus.if_req) begin
            starve_s = sat_inc4(starve_r, STARVE_MAX);
          end else begin
            starve_s = starve_r;
          end
`ifdef RV_MEM_TIMEOUT_EN
          tmo_s = 8'd0;
`endif
        end else if (bus.if_req) begin
          state_s    = BUSY_I;
          mem_req_s  = 1'b1;
          mem_we_s   = 1'b0;
          mem_addr_s = bus.if_addr;
          starve_s   = 4'd0;
`ifdef RV_MEM_TIMEOUT_EN
          tmo_s = 8'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end

      BUSY_I, BUSY_D: begin
        // mem_addr/we/wdata are left untouched for the whole BUSY period.
        if (bus.mem_ack) begin
          state_s   = IDLE;
          mem_req_s = 1'b0;
          if (state_r == BUSY_I) begin
            if_rdata_s = bus.mem_rdata;
            if_ready_s = 1'b1;
          end else begin
            d_ready_s = 1'b1;
            // Stores complete without disturbing the last load value.
            if (!mem_we_r) begin
              d_rdata_s = bus.mem_rdata;
            end else begin
              d_rdata_s = d_rdata_r;
            end
          end
        end
`ifdef RV_MEM_TIMEOUT_EN
        else if (tmo_r >= TMO_LAST) begin
          state_s   = IDLE;
          mem_req_s = 1'b0;
          mem_err_s = 1'b1;
          if (state_r == BUSY_I) begin
            if_rdata_s = 32'h0000_0000;
            if_ready_s = 1'b1;
          end else begin
            d_rdata_s = 32'h0000_0000;
            d_ready_s = 1'b1;
          end
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
`else
        else begin
          state_s = state_r;
        end
`endif
      end

      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs and arbitration counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_r    <= 4'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      if_rdata_r  <= 32'h0000_0000;
      d_rdata_r   <= 32'h0000_0000;
      if_ready_r  <= 1'b0;
      d_ready_r   <= 1'b0;
      mem_err_r   <= 1'b0;
    end else begin
      starve_r    <= starve_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_rdata_r  <= if_rdata_s;
      d_rdata_r   <= d_rdata_s;
      if_ready_r  <= if_ready_s;
      d_ready_r   <= d_ready_s;
      mem_err_r   <= mem_err_s;
    end
  end

`ifdef RV_MEM_TIMEOUT_EN
  // Watchdog counter for the current BUSY period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r <= 8'd0;
    end else begin
      tmo_r <= tmo_s;
    end
  end
`endif

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.d_ready   = d_ready_r;
  assign bus.mem_err   = mem_err_r;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
//-----------------------------------------------------------------------------
// tb_rv_mem_arbiter
// Directed bench for rv_mem_arbiter. The memory is either acked by hand
// (ack_man/rdata_man) or by a zero-wait model that acks every mem_req cycle
// and returns mem_addr ^ RD_MASK as read data.
//-----------------------------------------------------------------------------
module tb_rv_mem_arbiter;

  localparam logic [31:0] RD_MASK = 32'hA5A5_0000;

  logic clk;
  logic reset;
  logic ack_auto;
  logic ack_man;
  logic [31:0] rdata_man;

  int vec_cnt;
  int miss_cnt;

  rv_mem_arbiter_if bus ();

  rv_mem_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_ack   = ack_auto ? bus.mem_req : ack_man;
  assign bus.mem_rdata = ack_auto ? (bus.mem_addr ^ RD_MASK) : rdata_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vec_cnt     = 0;
    miss_cnt    = 0;
    reset       = 1'b1;
    ack_auto    = 1'b0;
    ack_man     = 1'b0;
    rdata_man   = 32'h0000_0000;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0000_0000;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_0000;
    bus.d_wdata = 32'h0000_0000;

    // ---- reset state ----
    #2;
    chk("rst_mem_req",   {31'd0, bus.mem_req},  32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
    chk("rst_mem_addr",  bus.mem_addr,          32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,         32'd0);
    chk("rst_if_ready",  {31'd0, bus.if_ready}, 32'd0);
    chk("rst_d_ready",   {31'd0, bus.d_ready},  32'd0);
    chk("rst_if_rdata",  bus.if_rdata,          32'd0);
    chk("rst_d_rdata",   bus.d_rdata,           32'd0);
    chk("rst_mem_err",   {31'd0, bus.mem_err},  32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // ---- IF-only, two wait cycles ----
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    tick();
    chk("if1_mem_req",  {31'd0, bus.mem_req},  32'd1);
    chk("if1_mem_addr", bus.mem_addr,          32'h0000_0010);
    chk("if1_mem_we",   {31'd0, bus.mem_we},   32'd0);
    chk("if1_ready_c1", {31'd0, bus.if_ready}, 32'd0);
    tick();
    chk("if1_req_c2",   {31'd0, bus.mem_req},  32'd1);
    chk("if1_ready_c2", {31'd0, bus.if_ready}, 32'd0);
    tick();
    chk("if1_ready_c3", {31'd0, bus.if_ready}, 32'd0);
    ack_man   = 1'b1;
    rdata_man = 32'h0050_0093;
    tick();
    chk("if1_ready",    {31'd0, bus.if_ready}, 32'd1);
    chk("if1_rdata",    bus.if_rdata,          32'h0050_0093);
    chk("if1_req_drop", {31'd0, bus.mem_req},  32'd0);
    chk("if1_no_dready",{31'd0, bus.d_ready},  32'd0);
    ack_man     = 1'b0;
    rdata_man   = 32'hFFFF_FFFF;
    bus.if_req  = 1'b0;
    tick();
    chk("if1_pulse_end",{31'd0, bus.if_ready}, 32'd0);
    chk("if1_idle",     {31'd0, bus.mem_req},  32'd0);

    // ---- mem_ack while IDLE is ignored ----
    ack_man = 1'b1;
    tick();
    tick();
    chk("idle_ack_if",  {31'd0, bus.if_ready}, 32'd0);
    chk("idle_ack_d",   {31'd0, bus.d_ready},  32'd0);
    chk("idle_ack_req", {31'd0, bus.mem_req},  32'd0);
    chk("idle_ack_irdata", bus.if_rdata,       32'h0050_0093);
    ack_man = 1'b0;

    // ---- simultaneous requests, zero-wait memory, store first ----
    ack_auto    = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0020;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("sim_d_addr",   bus.mem_addr,          32'h0000_0100);
    chk("sim_d_we",     {31'd0, bus.mem_we},   32'd1);
    chk("sim_d_wdata",  bus.mem_wdata,         32'hDEAD_BEEF);
    chk("sim_d_req",    {31'd0, bus.mem_req},  32'd1);
    tick();
    chk("sim_d_ready",  {31'd0, bus.d_ready},  32'd1);
    chk("sim_no_iready",{31'd0, bus.if_ready}, 32'd0);
    chk("sim_bubble",   {31'd0, bus.mem_req},  32'd0);
    chk("sim_d_rdata",  bus.d_rdata,           32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    chk("sim_i_addr",   bus.mem_addr,          32'h0000_0020);
    chk("sim_i_we",     {31'd0, bus.mem_we},   32'd0);
    chk("sim_i_dready", {31'd0, bus.d_ready},  32'd0);
    tick();
    chk("sim_i_ready",  {31'd0, bus.if_ready}, 32'd1);
    chk("sim_i_rdata",  bus.if_rdata,          32'h0000_0020 ^ RD_MASK);
    chk("sim_d_keep",   bus.d_rdata,           32'd0);
    bus.if_req = 1'b0;
    tick();
    chk("sim_idle",     {31'd0, bus.mem_req},  32'd0);

    // ---- starvation: four data grants, then fetch, then data again ----
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stv_d_addr",   bus.mem_addr, 32'h0000_1000 + 32'(i) * 32'd4);
      chk("stv_d_nordy",  {31'd0, bus.d_ready},  32'd0);
      chk("stv_i_nordy",  {31'd0, bus.if_ready}, 32'd0);
      tick();
      chk("stv_d_ready",  {31'd0, bus.d_ready},  32'd1);
      chk("stv_i_wait",   {31'd0, bus.if_ready}, 32'd0);
      chk("stv_d_rdata",  bus.d_rdata,
          (32'h0000_1000 + 32'(i) * 32'd4) ^ RD_MASK);
      bus.d_addr = bus.d_addr + 32'd4;
    end
    tick();
    chk("stv_i_addr",   bus.mem_addr,          32'h0000_0040);
    chk("stv_i_we",     {31'd0, bus.mem_we},   32'd0);
    tick();
    chk("stv_i_ready",  {31'd0, bus.if_ready}, 32'd1);
    chk("stv_i_dnordy", {31'd0, bus.d_ready},  32'd0);
    chk("stv_i_rdata",  bus.if_rdata,          32'h0000_0040 ^ RD_MASK);
    bus.if_req = 1'b0;
    tick();
    chk("stv_d_resume", bus.mem_addr,          32'h0000_1010);
    tick();
    chk("stv_d_ready5", {31'd0, bus.d_ready},  32'd1);
    chk("stv_d_rdata5", bus.d_rdata,           32'h0000_1010 ^ RD_MASK);
    bus.d_req = 1'b0;
    tick();
    chk("stv_idle",     {31'd0, bus.mem_req},  32'd0);

    // ---- stability of mem_* during BUSY_D, requester drops early ----
    ack_auto    = 1'b0;
    ack_man     = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_0200;
    tick();
    chk("stb_addr0",    bus.mem_addr,          32'h0000_0200);
    bus.d_addr  = 32'h0000_0300;
    bus.d_we    = 1'b1;
    bus.d_wdata = 32'h1234_5678;
    tick();
    chk("stb_addr1",    bus.mem_addr,          32'h0000_0200);
    chk("stb_we1",      {31'd0, bus.mem_we},   32'd0);
    bus.d_req = 1'b0;
    tick();
    chk("stb_addr2",    bus.mem_addr,          32'h0000_0200);
    chk("stb_req2",     {31'd0, bus.mem_req},  32'd1);
    ack_man   = 1'b1;
    rdata_man = 32'hCAFE_F00D;
    tick();
    chk("stb_d_ready",  {31'd0, bus.d_ready},  32'd1);
    chk("stb_d_rdata",  bus.d_rdata,           32'hCAFE_F00D);
    chk("stb_req_drop", {31'd0, bus.mem_req},  32'd0);
    ack_man = 1'b0;
    tick();
    chk("stb_idle",     {31'd0, bus.mem_req},  32'd0);
    chk("stb_pulse_end",{31'd0, bus.d_ready},  32'd0);

    // ---- reset asserted mid-transfer ----
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0500;
    tick();
    chk("rmt_req_on",   {31'd0, bus.mem_req},  32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rmt_req_kill", {31'd0, bus.mem_req},  32'd0);
    chk("rmt_d_ready",  {31'd0, bus.d_ready},  32'd0);
    chk("rmt_addr_clr", bus.mem_addr,          32'd0);
    bus.d_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rmt_idle",     {31'd0, bus.mem_req},  32'd0);
    chk("rmt_no_dready",{31'd0, bus.d_ready},  32'd0);
    ack_auto    = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0080;
    tick();
    chk("rmt_if_addr",  bus.mem_addr,          32'h0000_0080);
    chk("rmt_if_req",   {31'd0, bus.mem_req},  32'd1);
    tick();
    chk("rmt_if_ready", {31'd0, bus.if_ready}, 32'd1);
    chk("rmt_if_rdata", bus.if_rdata,          32'h0000_0080 ^ RD_MASK);
    bus.if_req = 1'b0;
    tick();
    chk("rmt_err",      {31'd0, bus.mem_err},  32'd0);

`ifdef RV_MEM_TIMEOUT_EN
    // ---- timeout abort after 8 ack-less BUSY cycles ----
    ack_auto    = 1'b0;
    ack_man     = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0090;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tmo_req_held", {31'd0, bus.mem_req},  32'd1);
      chk("tmo_no_err",   {31'd0, bus.mem_err},  32'd0);
    end
    bus.if_req = 1'b0;
    tick();
    chk("tmo_req_drop", {31'd0, bus.mem_req},  32'd0);
    chk("tmo_if_ready", {31'd0, bus.if_ready}, 32'd1);
    chk("tmo_if_rdata", bus.if_rdata,          32'd0);
    chk("tmo_err",      {31'd0, bus.mem_err},  32'd1);
    tick();
    chk("tmo_err_end",  {31'd0, bus.mem_err},  32'd0);
    chk("tmo_rdy_end",  {31'd0, bus.if_ready}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
